// File: rtl/bnn_core_exec.sv
// bnn_core_exec: execution datapath for the BNN controller's bnncore_ctrl word.
// Holds the weight/image/bias registers, a saturating XNOR-popcount accumulator,
// binarize/max-pool logic and the 16-bit packed output register.
// Everything except STORE executes from the registered control word so it lines up
// with SRAM read data, which arrives one cycle after the address.

module bnn_core_exec #(
  parameter int unsigned NCOL  = 4,
  parameter int unsigned ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [16:0]      bnncore_ctrl,
  input  logic [15:0]      sram_rdata,
  output logic [15:0]      sram_wdata,
  output logic             out_bit,
  output logic [4:0]       out_cnt,
  output logic             out_ovf,
  output logic [ACC_W-1:0] acc_dbg
);

  // Accumulator sum width: two guard bits cover acc plus both deltas without wrap.
  localparam int unsigned SumW = ACC_W + 2;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [16:0]      ctrl_q;
  logic [15:0]      w_q   [NCOL];
  logic [15:0]      w_d   [NCOL];
  logic [15:0]      img_q [NCOL];
  logic [15:0]      img_d [NCOL];
  logic [15:0]      bias_q, bias_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [15:0]      out_reg_q, out_reg_d;
  logic [2:0]       pool_q, pool_d;
  logic [4:0]       out_cnt_q, out_cnt_d;
  logic             out_ovf_q, out_ovf_d;
  logic             out_bit_q, out_bit_d;

  // ---------------------------------------------------------------------------
  // Decode of the registered control word
  // ---------------------------------------------------------------------------
  logic [1:0] col;
  logic       op_empt, op_byte_hi, op_bpue, op_neg, op_wgt, op_img, op_bpuc;
  logic       op_out, op_bias, op_pool, op_shift, op_img_hi;
  logic [1:0] pool_idx;
  logic       st_clr;

  assign col        = ctrl_q[2:1];
  assign op_empt    = ctrl_q[0];
  assign op_byte_hi = ctrl_q[3];
  assign op_bpue    = ctrl_q[5];
  assign op_neg     = ctrl_q[6];
  assign op_wgt     = ctrl_q[7];
  assign op_img     = ctrl_q[8];
  assign op_bpuc    = ctrl_q[9];
  assign op_out     = ctrl_q[10];
  assign op_bias    = ctrl_q[11];
  assign op_pool    = ctrl_q[12];
  assign op_shift   = ctrl_q[15];
  assign op_img_hi  = ctrl_q[16];
  assign pool_idx   = {ctrl_q[13], ctrl_q[6]};

  // STORE is decoded from the raw word; only the clear variant changes state.
  assign st_clr = bnncore_ctrl[14] & bnncore_ctrl[6];

  // ctrl_q[4] is a don't-care; ctrl_q[14] is unused since STORE acts on the raw word.
  logic unused_ctrl_bits;
  assign unused_ctrl_bits = ctrl_q[4] ^ ctrl_q[14];

  function automatic logic [4:0] popcnt16(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) begin
      c = c + {4'b0, v[i]};
    end
    return c;
  endfunction

  // ---------------------------------------------------------------------------
  // Operand registers
  // ---------------------------------------------------------------------------

  // Weight column load from SRAM read data.
  always_comb begin
    w_d = w_q;
    if (op_wgt) begin
      w_d[col] = sram_rdata;
    end
  end

  // Image shift-up first, then the byte load lands in the shifted array.
  always_comb begin
    img_d = img_q;
    if (op_shift) begin
      for (int k = 0; k < int'(NCOL) - 1; k++) begin
        img_d[k] = img_q[k+1];
      end
      img_d[NCOL-1] = '0;
    end
    if (op_img) begin
      if (op_img_hi) begin
        img_d[col][15:8] = sram_rdata[7:0];
      end else begin
        img_d[col][7:0] = sram_rdata[7:0];
      end
    end
  end

  // Bias load.
  always_comb begin
    bias_d = op_bias ? sram_rdata : bias_q;
  end

  // ---------------------------------------------------------------------------
  // XNOR-popcount accumulator
  // ---------------------------------------------------------------------------
  logic [15:0]     xnor_col;
  logic [7:0]      xnor_byte;
  logic [4:0]      pc_byte, pc_col;
  logic [SumW-1:0] d_byte, d_col, acc_sum;
  logic [2:0]      sum_top;
  logic [ACC_W-1:0] acc_sat;

  // Per-column match popcounts for the byte and full-column adds.
  always_comb begin
    xnor_col  = ~(w_q[col] ^ img_q[col]);
    xnor_byte = op_byte_hi ? xnor_col[15:8] : xnor_col[7:0];
    pc_byte   = popcnt16({8'h00, xnor_byte});
    pc_col    = popcnt16(xnor_col);
  end

  // Signed deltas, summed in a widened two's-complement domain, then clamped.
  always_comb begin
    d_byte = (SumW'(pc_byte) << 1) - SumW'(8);
    if (op_neg) begin
      d_byte = SumW'(0) - d_byte;
    end
    d_col   = (SumW'(pc_col) << 1) - SumW'(16);
    acc_sum = {{2{acc_q[ACC_W-1]}}, acc_q}
            + (op_bpue ? d_byte : SumW'(0))
            + (op_bpuc ? d_col : SumW'(0));
    // In range iff the bits above the accumulator sign all agree with it.
    sum_top = acc_sum[SumW-1:ACC_W-1];
    if ((&sum_top) | ~(|sum_top)) begin
      acc_sat = acc_sum[ACC_W-1:0];
    end else if (acc_sum[SumW-1]) begin
      acc_sat = {1'b1, {(ACC_W-1){1'b0}}};
    end else begin
      acc_sat = {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

  // Clear wins over any same-cycle add.
  always_comb begin
    acc_d = acc_q;
    if (op_empt) begin
      acc_d = '0;
    end else if (op_bpue | op_bpuc) begin
      acc_d = acc_sat;
    end
  end

  // ---------------------------------------------------------------------------
  // Binarize, pool and pack
  // ---------------------------------------------------------------------------
  logic [ACC_W:0] bin_sum;
  logic           bin_bit;
  logic           pack_en, pack_val;
  logic [15:0]    out_reg_fwd;

  // Sign of acc + bias at one extra bit so large sums cannot flip the result.
  always_comb begin
    bin_sum = {acc_q[ACC_W-1], acc_q} + {{(ACC_W-15){bias_q[15]}}, bias_q};
    bin_bit = ~bin_sum[ACC_W];
  end

  // Pack decision and the out_reg value after this edge, before any STORE clear.
  always_comb begin
    pack_en     = op_out & (~op_pool | (pool_idx == 2'd3));
    pack_val    = op_pool ? ((|pool_q) | bin_bit) : bin_bit;
    out_reg_fwd = pack_en ? {out_reg_q[14:0], pack_val} : out_reg_q;
  end

  // Pool slots fill at indices 0..2 and empty when index 3 packs.
  always_comb begin
    pool_d    = pool_q;
    out_bit_d = out_bit_q;
    if (op_out) begin
      out_bit_d = bin_bit;
      if (op_pool) begin
        if (pool_idx == 2'd3) begin
          pool_d = '0;
        end else begin
          pool_d[pool_idx] = bin_bit;
        end
      end
    end
  end

  // Output register bookkeeping; STORE-clear overrides the pack already forwarded.
  always_comb begin
    out_reg_d = out_reg_fwd;
    out_cnt_d = out_cnt_q;
    out_ovf_d = out_ovf_q;
    if (pack_en) begin
      if (out_cnt_q == 5'd16) begin
        out_ovf_d = 1'b1;
      end else begin
        out_cnt_d = out_cnt_q + 5'd1;
      end
    end
    if (st_clr) begin
      out_reg_d = '0;
      out_cnt_d = '0;
      out_ovf_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------

  // All state updates with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q <= '0;
      for (int k = 0; k < int'(NCOL); k++) begin
        w_q[k]   <= '0;
        img_q[k] <= '0;
      end
      bias_q    <= '0;
      acc_q     <= '0;
      out_reg_q <= '0;
      pool_q    <= '0;
      out_cnt_q <= '0;
      out_ovf_q <= 1'b0;
      out_bit_q <= 1'b0;
    end else begin
      ctrl_q    <= bnncore_ctrl;
      w_q       <= w_d;
      img_q     <= img_d;
      bias_q    <= bias_d;
      acc_q     <= acc_d;
      out_reg_q <= out_reg_d;
      pool_q    <= pool_d;
      out_cnt_q <= out_cnt_d;
      out_ovf_q <= out_ovf_d;
      out_bit_q <= out_bit_d;
    end
  end

  assign sram_wdata = out_reg_fwd;
  assign out_bit    = out_bit_q;
  assign out_cnt    = out_cnt_q;
  assign out_ovf    = out_ovf_q;
  assign acc_dbg    = acc_q;

endmodule

// File: tb/tb_bnn_core_exec.sv
// Directed bench for bnn_core_exec: a per-cycle vector table for the accumulate,
// bias and pooling path, plus hand sequences for load/reset, saturation,
// STORE forwarding, overflow and image shift-up.

module tb_bnn_core_exec;

  logic        clk;
  logic        rst;
  logic [16:0] bnncore_ctrl;
  logic [15:0] sram_rdata;
  logic [15:0] sram_wdata;
  logic        out_bit;
  logic [4:0]  out_cnt;
  logic        out_ovf;
  logic [15:0] acc_dbg;

  int errors;
  int n_checks;

  bnn_core_exec #(
    .NCOL  (4),
    .ACC_W (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bnncore_ctrl (bnncore_ctrl),
    .sram_rdata   (sram_rdata),
    .sram_wdata   (sram_wdata),
    .out_bit      (out_bit),
    .out_cnt      (out_cnt),
    .out_ovf      (out_ovf),
    .acc_dbg      (acc_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [16:0] ctrl;
    logic [15:0] rdata;
    logic [15:0] acc;
    logic        ob;
    logic [4:0]  cnt;
    logic        ovf;
    logic [15:0] wd;
  } vec_t;

  vec_t vecs [34];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle's control word and read data, then sample 1 ns after the edge.
  task automatic cyc(input logic [16:0] c, input logic [15:0] d);
    bnncore_ctrl = c;
    sram_rdata   = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    errors   = 0;
    n_checks = 0;

    // ctrl, rdata | expected after this edge: acc, out_bit, out_cnt, out_ovf, sram_wdata
    vecs[0]  = '{17'h00080, 16'h0000, 16'h0000, 1'b0, 5'd0, 1'b0, 16'h0000};
    vecs[1]  = '{17'h00100, 16'hFFFF, 16'h0000, 1'b0, 5'd0, 1'b0, 16'h0000};
    vecs[2]  = '{17'h10100, 16'h00FF, 16'h0000, 1'b0, 5'd0, 1'b0, 16'h0000};
    vecs[3]  = '{17'h00001, 16'h00FF, 16'h0000, 1'b0, 5'd0, 1'b0, 16'h0000};
    vecs[4]  = '{17'h00200, 16'h0000, 16'h0000, 1'b0, 5'd0, 1'b0, 16'h0000};
    vecs[5]  = '{17'h00200, 16'h0000, 16'h0010, 1'b0, 5'd0, 1'b0, 16'h0000};
    vecs[6]  = '{17'h00100, 16'h0000, 16'h0020, 1'b0, 5'd0, 1'b0, 16'h0000};
    vecs[7]  = '{17'h10100, 16'h0000, 16'h0020, 1'b0, 5'd0, 1'b0, 16'h0000};
    vecs[8]  = '{17'h00200, 16'h0000, 16'h0020, 1'b0, 5'd0, 1'b0, 16'h0000};
    vecs[9]  = '{17'h00000, 16'h0000, 16'h0010, 1'b0, 5'd0, 1'b0, 16'h0000};
    vecs[10] = '{17'h00080, 16'h0000, 16'h0010, 1'b0, 5'd0, 1'b0, 16'h0000};
    vecs[11] = '{17'h00001, 16'hFF00, 16'h0010, 1'b0, 5'd0, 1'b0, 16'h0000};
    vecs[12] = '{17'h00028, 16'h0000, 16'h0000, 1'b0, 5'd0, 1'b0, 16'h0000};
    vecs[13] = '{17'h00068, 16'h0000, 16'hFFF8, 1'b0, 5'd0, 1'b0, 16'h0000};
    vecs[14] = '{17'h00028, 16'h0000, 16'h0000, 1'b0, 5'd0, 1'b0, 16'h0000};
    vecs[15] = '{17'h00029, 16'h0000, 16'hFFF8, 1'b0, 5'd0, 1'b0, 16'h0000};
    vecs[16] = '{17'h00000, 16'h0000, 16'h0000, 1'b0, 5'd0, 1'b0, 16'h0000};
    vecs[17] = '{17'h00220, 16'h0000, 16'h0000, 1'b0, 5'd0, 1'b0, 16'h0000};
    vecs[18] = '{17'h00000, 16'h0000, 16'h0008, 1'b0, 5'd0, 1'b0, 16'h0000};
    vecs[19] = '{17'h00001, 16'h0000, 16'h0008, 1'b0, 5'd0, 1'b0, 16'h0000};
    vecs[20] = '{17'h00028, 16'h0000, 16'h0000, 1'b0, 5'd0, 1'b0, 16'h0000};
    vecs[21] = '{17'h00800, 16'h0000, 16'hFFF8, 1'b0, 5'd0, 1'b0, 16'h0000};
    vecs[22] = '{17'h00400, 16'h0007, 16'hFFF8, 1'b0, 5'd0, 1'b0, 16'h0000};
    vecs[23] = '{17'h00800, 16'h0000, 16'hFFF8, 1'b0, 5'd1, 1'b0, 16'h0000};
    vecs[24] = '{17'h00400, 16'h0008, 16'hFFF8, 1'b0, 5'd1, 1'b0, 16'h0001};
    vecs[25] = '{17'h00000, 16'h0000, 16'hFFF8, 1'b1, 5'd2, 1'b0, 16'h0001};
    vecs[26] = '{17'h00800, 16'h0000, 16'hFFF8, 1'b1, 5'd2, 1'b0, 16'h0001};
    vecs[27] = '{17'h01400, 16'h0007, 16'hFFF8, 1'b1, 5'd2, 1'b0, 16'h0001};
    vecs[28] = '{17'h01440, 16'h0000, 16'hFFF8, 1'b0, 5'd2, 1'b0, 16'h0001};
    vecs[29] = '{17'h00800, 16'h0000, 16'hFFF8, 1'b0, 5'd2, 1'b0, 16'h0001};
    vecs[30] = '{17'h03400, 16'h0008, 16'hFFF8, 1'b0, 5'd2, 1'b0, 16'h0001};
    vecs[31] = '{17'h00800, 16'h0000, 16'hFFF8, 1'b1, 5'd2, 1'b0, 16'h0001};
    vecs[32] = '{17'h03440, 16'h0007, 16'hFFF8, 1'b1, 5'd2, 1'b0, 16'h0003};
    vecs[33] = '{17'h00000, 16'h0000, 16'hFFF8, 1'b0, 5'd3, 1'b0, 16'h0003};

    // Reset state.
    rst          = 1'b1;
    bnncore_ctrl = '0;
    sram_rdata   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset acc", acc_dbg, 16'h0000);
    check("reset out_bit", out_bit, 1'b0);
    check("reset out_cnt", out_cnt, 5'd0);
    check("reset out_ovf", out_ovf, 1'b0);
    check("reset wdata", sram_wdata, 16'h0000);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("reset w%0d", k), dut.w_q[k], 16'h0000);
    end
    rst = 1'b0;

    // Weight load into column 2 with one-cycle read latency.
    cyc(17'h00084, 16'h0000);
    cyc(17'h00000, 16'hA5A5);
    check("wload w2", dut.w_q[2], 16'hA5A5);
    check("wload w0", dut.w_q[0], 16'h0000);
    check("wload w1", dut.w_q[1], 16'h0000);
    check("wload w3", dut.w_q[3], 16'h0000);

    // Reset during the read-data cycle leaves the column cleared.
    cyc(17'h00084, 16'h0000);
    rst = 1'b1;
    cyc(17'h00000, 16'h5A5A);
    rst = 1'b0;
    check("wload rst rdata cycle", dut.w_q[2], 16'h0000);

    // Load word captured under reset is dropped; later read data is ignored.
    rst = 1'b1;
    cyc(17'h00084, 16'h0000);
    rst = 1'b0;
    cyc(17'h00000, 16'h3C3C);
    check("wload discarded", dut.w_q[2], 16'h0000);

    // Table: BPUC/BPUE accumulate, bias binarize and pooling.
    for (int i = 0; i < 34; i++) begin
      cyc(vecs[i].ctrl, vecs[i].rdata);
      check($sformatf("vec%0d acc", i), acc_dbg, vecs[i].acc);
      check($sformatf("vec%0d out_bit", i), out_bit, vecs[i].ob);
      check($sformatf("vec%0d out_cnt", i), out_cnt, vecs[i].cnt);
      check($sformatf("vec%0d out_ovf", i), out_ovf, vecs[i].ovf);
      check($sformatf("vec%0d wdata", i), sram_wdata, vecs[i].wd);
    end

    // Positive saturation: column 1 is all-zero on both sides, so BPUC adds +16.
    cyc(17'h00001, 16'h0000);
    for (int i = 0; i < 2047; i++) begin
      cyc(17'h00202, 16'h0000);
    end
    cyc(17'h00022, 16'h0000);
    cyc(17'h00000, 16'h0000);
    check("sat preload", acc_dbg, 16'd32760);
    cyc(17'h00202, 16'h0000);
    cyc(17'h00000, 16'h0000);
    check("sat clamp", acc_dbg, 16'h7FFF);
    cyc(17'h00202, 16'h0000);
    cyc(17'h00000, 16'h0000);
    check("sat hold", acc_dbg, 16'h7FFF);

    // STORE-clear with an OUT pack in flight: acc+bias = 32774 must binarize to 1.
    cyc(17'h00400, 16'h0000);
    check("fwd pre-store wdata", sram_wdata, 16'h0007);
    bnncore_ctrl = 17'h04040;
    #1;
    check("fwd store wdata", sram_wdata, 16'h0007);
    @(posedge clk);
    #1;
    check("fwd clear out_cnt", out_cnt, 5'd0);
    check("fwd clear out_ovf", out_ovf, 1'b0);
    check("fwd clear wdata", sram_wdata, 16'h0000);
    check("fwd out_bit", out_bit, 1'b1);

    // Overflow: 17 packs of 1.
    for (int i = 0; i < 17; i++) begin
      cyc(17'h00400, 16'h0000);
    end
    check("ovf at16 cnt", out_cnt, 5'd16);
    check("ovf at16 flag", out_ovf, 1'b0);
    cyc(17'h04000, 16'h0000);
    check("ovf cnt", out_cnt, 5'd16);
    check("ovf flag", out_ovf, 1'b1);
    check("ovf wdata", sram_wdata, 16'hFFFF);
    cyc(17'h00000, 16'h0000);
    check("store noclr cnt", out_cnt, 5'd16);
    check("store noclr ovf", out_ovf, 1'b1);
    cyc(17'h04040, 16'h0000);
    check("clr cnt", out_cnt, 5'd0);
    check("clr ovf", out_ovf, 1'b0);
    check("clr wdata", sram_wdata, 16'h0000);

    // Shift-up with IMG = {1,2,3,4}, then shift combined with a column-3 load.
    cyc(17'h00100, 16'h0000);
    cyc(17'h00102, 16'h0001);
    cyc(17'h00104, 16'h0002);
    cyc(17'h00106, 16'h0003);
    cyc(17'h08000, 16'h0004);
    cyc(17'h00000, 16'h0000);
    check("shift img0", dut.img_q[0], 16'h0002);
    check("shift img1", dut.img_q[1], 16'h0003);
    check("shift img2", dut.img_q[2], 16'h0004);
    check("shift img3", dut.img_q[3], 16'h0000);
    cyc(17'h08106, 16'h0000);
    cyc(17'h00000, 16'h0009);
    check("shift+load img0", dut.img_q[0], 16'h0003);
    check("shift+load img1", dut.img_q[1], 16'h0004);
    check("shift+load img2", dut.img_q[2], 16'h0000);
    check("shift+load img3", dut.img_q[3], 16'h0009);

    $display("Result: errors=%0d of %0d checks", errors, n_checks);
    $finish;
  end

endmodule

// File: doc/bnn_core_exec.md
Name: bnn_core_exec

Overview:
- Execution end of the 17-bit bnncore_ctrl control word issued by the BNN controller.
- Holds the weight, image and bias registers, a signed XNOR-popcount accumulator, binarize/pool logic and a 16-bit packed output register.
- Consumes data SRAM read data; the SRAM returns read data one cycle after the controller issues an address.
- Drives data SRAM write data for STORE.

Parameters:
- NCOL, 4, number of weight/image columns; fixed at 4, selected by ctrl[2:1].
- ACC_W, 16, signed accumulator width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- bnncore_ctrl  in  17  control word from the controller, registered on its side.
- sram_rdata  in  16  data SRAM read data, valid the cycle after the load word.
- sram_wdata  out  16  data SRAM write data for STORE.
- out_bit  out  1  last binarized result.
- out_cnt  out  5  valid bits in out_reg (0..16).
- out_ovf  out  1  sticky flag: more than 16 bits were packed since the last clear.
- acc_dbg  out  16  current accumulator value.

Behaviour:
- Reset: ctrl_q, W[0..3], IMG[0..3], bias, acc, out_reg, pool_bits, out_cnt, out_ovf and out_bit all go to 0. sram_wdata therefore reads 0.
- Reset mid-operation: a load word in ctrl_q is discarded, and the following sram_rdata is not written.
- Pipeline: ctrl_q <= bnncore_ctrl every cycle. Every op except STORE executes from ctrl_q (1-cycle latency), aligned with sram_rdata. STORE decodes the raw bnncore_ctrl.
- Column select: col = ctrl_q[2:1].
- WGT (ctrl_q[7]): W[col] <= sram_rdata.
- IMG (ctrl_q[8]):
  - ctrl_q[16]=1: IMG[col][15:8] <= sram_rdata[7:0].
  - ctrl_q[16]=0: IMG[col][7:0] <= sram_rdata[7:0].
  - The other byte is held.
- BIAS (ctrl_q[11]): bias <= sram_rdata, treated as signed.
- SHIFT-UP (ctrl_q[15]): IMG[0]<=IMG[1], IMG[1]<=IMG[2], IMG[2]<=IMG[3], IMG[3]<=0.
  - If IMG load and SHIFT-UP are both set, the load applies after the shift to the selected column.
- EMPT (ctrl_q[0]): acc <= 0. It overrides any same-cycle add.
- BPUE (ctrl_q[5]): byte-level add.
  - Byte = high byte if ctrl_q[3], else low byte, of column ctrl_q[2:1].
  - p = popcount(~(W ^ IMG)) over that byte, 0..8.
  - d = 2p-8; negated if ctrl_q[6].
  - acc <= sat(acc+d).
- BPUC (ctrl_q[9]): full-column add.
  - p = popcount over all 16 bits of column ctrl_q[2:1].
  - d = 2p-16; ctrl_q[4:3] are ignored.
  - acc <= sat(acc+d).
  - If BPUE and BPUC are both set, both deltas are summed before saturation.
- Saturation: clamp to [-32768, 32767]; no wrap-around.
- OUT (ctrl_q[10]):
  - b = ((acc + bias), computed at 17 bits signed) >= 0; out_bit <= b.
  - ctrl_q[12]=0: pack b.
  - ctrl_q[12]=1: pool index i = {ctrl_q[13], ctrl_q[6]}.
    - i<3: pool_bits[i] <= b; nothing is packed.
    - i=3: pack (pool_bits[0] | pool_bits[1] | pool_bits[2] | b), binary max-pool; pool_bits <= 0.
- Pack: out_reg <= {out_reg[14:0], bit}; out_cnt <= min(out_cnt+1, 16). If out_cnt was already 16, out_ovf <= 1 and the MSB is lost.
- STORE (bnncore_ctrl[14]), forwarding:
  - sram_wdata equals the value out_reg will hold after the current edge, including any pack from ctrl_q.
  - Outside STORE, sram_wdata still shows this value.
- STORE clear (bnncore_ctrl[14] & bnncore_ctrl[6]):
  - At the edge: out_reg <= 0, out_cnt <= 0, out_ovf <= 0.
  - The clear takes priority over the same-edge pack, which has already been forwarded to the SRAM.
- STORE with bnncore_ctrl[6]=0: no state change.
- sram_rdata is ignored in cycles with no load bit set in ctrl_q.

Test Plan:
- Weight load: bnncore_ctrl=0x0084, next cycle sram_rdata=0xA5A5 -> W[2]=0xA5A5 after that edge; W[0,1,3] unchanged. Same with rst asserted in the rdata cycle -> W[2]=0.
- BPUC: W[0]=IMG[0]=0xFFFF, EMPT then two BPUC col0 -> acc_dbg 16 then 32. IMG[0]=0x0000, one BPUC -> acc_dbg 16. Preload acc=32760 plus one +16 -> 32767.
- BPUE: W[0]=0xFF00, IMG[0]=0x0000, ctrl_q[3]=1 -> acc -8; with ctrl_q[6]=1 -> +8. EMPT+BPUE in the same word -> acc 0.
- OUT/bias: acc=-5, bias=4 -> out_bit 0. Bias=5 -> out_bit 1. Pooled bits 0,0,1 at i=0..2, then b=0 at i=3 -> one packed bit =1, out_cnt+1.
- Store forwarding: out_reg=0x0003, OUT with b=1 in ctrl_q, STORE with ctrl[6]=1 same cycle -> sram_wdata=0x0007; next cycle out_reg=0, out_cnt=0.
- Overflow/shift: 17 packs of 1 -> out_cnt 16, out_ovf 1, out_reg 0xFFFF. SHIFT-UP with IMG={1,2,3,4} -> {2,3,4,0}.
